fetch_queue: RTL and testbench

Instruction fetch front end: owns the PC, looks up the branch predictor and issues word requests to the instruction cache. Returned words are delivered in order to `decode` over the `fetch_de_*` / `decode_stall` interface. Each fetch allocates a slot in a small in-order queue at request time, and the slot is filled when the cache responds. On `rob_flush` the block clears all queued work, discards responses still in flight, and restarts at the flush target.

---
 rtl/fetch_queue.sv | 169 ++++++++++++++++
 tb/tb_fetch_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, issues in-order word requests to the
// instruction cache and queues returned words for decode, with flush/redirect.
module fetch_queue #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int          DEPTH      = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        fetch_ic_req,
   output logic [29:0] fetch_ic_addr,
   input  logic        ic_fetch_ready,
   input  logic        ic_fetch_valid,
   input  logic [31:0] ic_fetch_insn,
   input  logic        ic_fetch_error,
   output logic [30:0] fetch_bp_addr,
   input  logic        bp_fetch_taken,
   input  logic [30:0] bp_fetch_target,
   input  logic [15:0] bp_fetch_tag,
   input  logic        rob_flush,
   input  logic [30:0] rob_flush_addr,
   output logic        fetch_de_valid,
   output logic        fetch_de_error,
   output logic [30:0] fetch_de_addr,
   output logic [31:0] fetch_de_insn,
   output logic [15:0] fetch_de_bptag,
   output logic        fetch_de_bptaken,
   input  logic        decode_stall
);

   localparam int PW = $clog2(DEPTH);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   cnt_t;

   typedef struct packed {
      logic [30:0] addr;
      logic [15:0] tag;
      logic        taken;
      logic [31:0] insn;
      logic        error;
      logic        filled;
   } slot_t;

   slot_t       slots_q [DEPTH];
   slot_t       slots_d [DEPTH];
   ptr_t        head_q, head_d;
   ptr_t        tail_q, tail_d;
   ptr_t        fill_q, fill_d;
   cnt_t        count_q, count_d;
   cnt_t        pend_q, pend_d;   // requests in flight that will fill a slot
   cnt_t        drop_q, drop_d;   // requests in flight whose responses are discarded
   logic        halt_q, halt_d;
   logic [30:0] pc_q, pc_d;

   logic  can_alloc;
   logic  issue;
   logic  accept;
   logic  misalign;
   logic  fill_en;
   logic  deq;
   slot_t head_slot;

   // A misaligned PC needs no cache access, so it does not wait for drop to clear.
   assign can_alloc = ~rst & ~halt_q & ~rob_flush & (count_q != cnt_t'(DEPTH));
   assign issue     = can_alloc & (drop_q == '0) & ~pc_q[0];
   assign misalign  = can_alloc & pc_q[0];
   assign accept    = issue & ic_fetch_ready;
   assign fill_en   = ic_fetch_valid & ~rob_flush & (drop_q == '0);

   assign fetch_ic_req  = issue;
   assign fetch_ic_addr = pc_q[30:1];
   assign fetch_bp_addr = pc_q;

   assign head_slot        = slots_q[head_q];
   assign fetch_de_valid   = ~rst & (count_q != '0) & head_slot.filled;
   assign fetch_de_error   = head_slot.error;
   assign fetch_de_addr    = head_slot.addr;
   assign fetch_de_insn    = head_slot.insn;
   assign fetch_de_bptag   = head_slot.tag;
   assign fetch_de_bptaken = head_slot.taken;

   assign deq = fetch_de_valid & ~decode_stall & ~rob_flush;

   always_comb begin
      slots_d = slots_q;
      head_d  = head_q;
      tail_d  = tail_q;
      fill_d  = fill_q;
      count_d = count_q;
      pend_d  = pend_q;
      drop_d  = drop_q;
      halt_d  = halt_q;
      pc_d    = pc_q;

      if (rob_flush) begin
         head_d  = '0;
         tail_d  = '0;
         fill_d  = '0;
         count_d = '0;
         pend_d  = '0;
         // Everything on the bus becomes stale, minus a response consumed right now.
         drop_d  = pend_q + drop_q - cnt_t'(ic_fetch_valid);
         halt_d  = 1'b0;
         pc_d    = rob_flush_addr;
      end else begin
         if (ic_fetch_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - cnt_t'(1);
            end else begin
               slots_d[fill_q].insn   = ic_fetch_error ? 32'h0 : ic_fetch_insn;
               slots_d[fill_q].error  = ic_fetch_error;
               slots_d[fill_q].filled = 1'b1;
               fill_d = fill_q + ptr_t'(1);
               if (ic_fetch_error) halt_d = 1'b1;
            end
         end

         pend_d = pend_q + cnt_t'(accept) - cnt_t'(fill_en);

         if (accept) begin
            slots_d[tail_q].addr   = pc_q;
            slots_d[tail_q].tag    = bp_fetch_tag;
            slots_d[tail_q].taken  = bp_fetch_taken;
            slots_d[tail_q].insn   = 32'h0;
            slots_d[tail_q].error  = 1'b0;
            slots_d[tail_q].filled = 1'b0;
            tail_d = tail_q + ptr_t'(1);
            pc_d   = bp_fetch_taken ? bp_fetch_target : pc_q + 31'd2;
         end else if (misalign) begin
            slots_d[tail_q].addr   = pc_q;
            slots_d[tail_q].tag    = 16'h0;
            slots_d[tail_q].taken  = 1'b0;
            slots_d[tail_q].insn   = 32'h0;
            slots_d[tail_q].error  = 1'b1;
            slots_d[tail_q].filled = 1'b1;
            tail_d = tail_q + ptr_t'(1);
            halt_d = 1'b1;
         end

         if (deq) head_d = head_q + ptr_t'(1);
         count_d = count_q + cnt_t'(accept | misalign) - cnt_t'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) slots_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         fill_q  <= '0;
         count_q <= '0;
         pend_q  <= '0;
         drop_q  <= '0;
         halt_q  <= 1'b0;
         pc_q    <= RESET_ADDR[31:1];
      end else begin
         slots_q <= slots_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         fill_q  <= fill_d;
         count_q <= count_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         halt_q  <= halt_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: drives an in-order cache and predictor and
// compares every output each cycle against a queue-based reference model.
module tb_fetch_queue;

   localparam int          DEPTH      = 4;
   localparam logic [31:0] RESET_ADDR = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_ic_req;
   logic [29:0] fetch_ic_addr;
   logic        ic_fetch_ready;
   logic        ic_fetch_valid;
   logic [31:0] ic_fetch_insn;
   logic        ic_fetch_error;
   logic [30:0] fetch_bp_addr;
   logic        bp_fetch_taken;
   logic [30:0] bp_fetch_target;
   logic [15:0] bp_fetch_tag;
   logic        rob_flush;
   logic [30:0] rob_flush_addr;
   logic        fetch_de_valid;
   logic        fetch_de_error;
   logic [30:0] fetch_de_addr;
   logic [31:0] fetch_de_insn;
   logic [15:0] fetch_de_bptag;
   logic        fetch_de_bptaken;
   logic        decode_stall;

   always #5 clk = ~clk;

   fetch_queue #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .fetch_ic_req     (fetch_ic_req),
      .fetch_ic_addr    (fetch_ic_addr),
      .ic_fetch_ready   (ic_fetch_ready),
      .ic_fetch_valid   (ic_fetch_valid),
      .ic_fetch_insn    (ic_fetch_insn),
      .ic_fetch_error   (ic_fetch_error),
      .fetch_bp_addr    (fetch_bp_addr),
      .bp_fetch_taken   (bp_fetch_taken),
      .bp_fetch_target  (bp_fetch_target),
      .bp_fetch_tag     (bp_fetch_tag),
      .rob_flush        (rob_flush),
      .rob_flush_addr   (rob_flush_addr),
      .fetch_de_valid   (fetch_de_valid),
      .fetch_de_error   (fetch_de_error),
      .fetch_de_addr    (fetch_de_addr),
      .fetch_de_insn    (fetch_de_insn),
      .fetch_de_bptag   (fetch_de_bptag),
      .fetch_de_bptaken (fetch_de_bptaken),
      .decode_stall     (decode_stall)
   );

   typedef struct {
      logic [30:0] addr;
      logic [15:0] tag;
      logic        taken;
      logic [31:0] insn;
      logic        error;
      logic        filled;
   } ent_t;

   typedef struct {
      bit          stale;
      int          due;
      logic [31:0] insn;
      logic        err;
   } req_t;

   ent_t        mq[$];   // expected fetch queue, oldest first
   req_t        cq[$];   // requests on the cache bus, oldest first
   logic [30:0] m_pc;
   bit          m_halt;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      int          cyc;
      int          stall_pct;
      int          flush_div;
      int          lat_max;
      bit          resp_v;
      bit          exp_req;
      bit          exp_dv;
      bit          deq;
      int          stale_n;
      logic [31:0] r;
      req_t        rq;
      req_t        resp;

      rst = 1'b1;
      ic_fetch_ready = 1'b0; ic_fetch_valid = 1'b0; ic_fetch_insn = '0; ic_fetch_error = 1'b0;
      bp_fetch_taken = 1'b0; bp_fetch_target = '0; bp_fetch_tag = '0;
      rob_flush = 1'b0; rob_flush_addr = '0; decode_stall = 1'b0;
      m_pc   = RESET_ADDR[31:1];
      m_halt = 0;

      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #3;
         check_eq("rst_ic_req", 64'(fetch_ic_req), 64'd0);
         check_eq("rst_de_valid", 64'(fetch_de_valid), 64'd0);
      end

      cyc = 0;
      for (int ph = 0; ph < 15; ph++) begin
         stall_pct = (ph == 0) ? 0 : $urandom_range(0, 90);
         flush_div = (ph == 0) ? 1000000 : $urandom_range(10, 60);
         lat_max   = (ph == 0) ? 1 : $urandom_range(1, 6);
         for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            cyc++;

            decode_stall   = ($urandom_range(0, 99) < stall_pct);
            rob_flush      = ($urandom_range(0, flush_div - 1) == 0);
            r              = $urandom();
            rob_flush_addr = {r[30:1], ($urandom_range(0, 3) == 0)};
            bp_fetch_taken = (ph != 0) && ($urandom_range(0, 4) == 0);
            r              = $urandom();
            bp_fetch_target = {r[30:1], ($urandom_range(0, 7) == 0)};
            bp_fetch_tag   = 16'($urandom());
            ic_fetch_ready = (ph == 0) || ($urandom_range(0, 4) != 0);
            resp_v = (cq.size() > 0) && (cq[0].due <= cyc) && ((ph == 0) || ($urandom_range(0, 3) != 0));
            ic_fetch_valid = resp_v;
            ic_fetch_insn  = resp_v ? cq[0].insn : $urandom();
            ic_fetch_error = resp_v ? cq[0].err : 1'($urandom());
            #2;

            stale_n = 0;
            foreach (cq[i]) if (cq[i].stale) stale_n++;
            exp_req = !m_halt && !rob_flush && (mq.size() < DEPTH) && (stale_n == 0) && !m_pc[0];
            exp_dv  = (mq.size() > 0) && mq[0].filled;

            check_eq("ic_req", 64'(fetch_ic_req), 64'(exp_req));
            check_eq("bp_addr", 64'(fetch_bp_addr), 64'(m_pc));
            if (exp_req) check_eq("ic_addr", 64'(fetch_ic_addr), 64'(m_pc[30:1]));
            check_eq("de_valid", 64'(fetch_de_valid), 64'(exp_dv));
            if (exp_dv) begin
               check_eq("de_addr", 64'(fetch_de_addr), 64'(mq[0].addr));
               check_eq("de_error", 64'(fetch_de_error), 64'(mq[0].error));
               check_eq("de_insn", 64'(fetch_de_insn), 64'(mq[0].insn));
               check_eq("de_tag", 64'(fetch_de_bptag), 64'(mq[0].tag));
               check_eq("de_taken", 64'(fetch_de_bptaken), 64'(mq[0].taken));
            end

            if (rob_flush) begin
               if (resp_v) void'(cq.pop_front());
               foreach (cq[i]) cq[i].stale = 1;
               mq.delete();
               m_halt = 0;
               m_pc   = rob_flush_addr;
            end else begin
               bit new_halt;
               new_halt = m_halt;
               deq = exp_dv && !decode_stall;
               if (resp_v) begin
                  resp = cq.pop_front();
                  if (!resp.stale) begin
                     for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                           mq[i].insn   = resp.err ? 32'h0 : resp.insn;
                           mq[i].error  = resp.err;
                           mq[i].filled = 1'b1;
                           break;
                        end
                     end
                     if (resp.err) new_halt = 1;
                  end
               end
               if (exp_req && ic_fetch_ready) begin
                  mq.push_back('{addr: m_pc, tag: bp_fetch_tag, taken: bp_fetch_taken,
                                 insn: 32'h0, error: 1'b0, filled: 1'b0});
                  rq.stale = 0;
                  rq.due   = cyc + $urandom_range(1, lat_max);
                  rq.insn  = $urandom();
                  rq.err   = ($urandom_range(0, 29) == 0);
                  cq.push_back(rq);
                  m_pc = bp_fetch_taken ? bp_fetch_target : m_pc + 31'd2;
               end else if (!m_halt && (mq.size() < DEPTH) && m_pc[0]) begin
                  mq.push_back('{addr: m_pc, tag: 16'h0, taken: 1'b0,
                                 insn: 32'h0, error: 1'b1, filled: 1'b1});
                  new_halt = 1;
               end
               if (deq) void'(mq.pop_front());
               m_halt = new_halt;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
